// File: rtl/decode_ctrl_stage.sv
// RV64 decode/control stage: decodes ID fields into the execute control bundle, registers it
// into ID/EX with stall/flush, and sequences multi-cycle MUL/DIV by stalling the front end.
module decode_ctrl_stage #(
  parameter int M_EXT   = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 34
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       valid_i,
  input  logic       stall_i,
  input  logic       flush_i,
  output logic       regWrite_e,
  output logic [2:0] immSrc_e,
  output logic       ALUSrc_e,
  output logic [3:0] ALUControl_e,
  output logic       ALU32_e,
  output logic       memWrite_e,
  output logic [2:0] memType_e,
  output logic [2:0] resultSrc_e,
  output logic       branch_e,
  output logic       jal_e,
  output logic       jalr_e,
  output logic       ecall_e,
  output logic       illegal_e,
  output logic       mdStart_e,
  output logic       mdStall_o,
  output logic       mdDone_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
  localparam logic [2:0] RES_MEM = 3'd1, RES_PC4 = 3'd2, RES_IMM = 3'd3;
  localparam logic [2:0] RES_PCIMM = 3'd4, RES_MD = 3'd5;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [7:0] MUL_LAT_C = 8'(MUL_LAT);
  localparam logic [7:0] DIV_LAT_C = 8'(DIV_LAT);

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic [3:0] alu_ctrl;
    logic       alu32;
    logic       mem_write;
    logic [2:0] mem_type;
    logic [2:0] result_src;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       ecall;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(22'd0);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  ctrl_t      dec_s, ctrl_r;
  logic       is_md_s, hold_s, load_s;
  logic [7:0] lat_s, cnt_s, cnt_r;
  state_t     state_s, state_r;
  logic       md_start_r, md_stall_r, md_done_r;

  // Combinational decode of the instruction currently in ID
  always_comb begin
    dec_s   = CTRL_BUBBLE;
    is_md_s = 1'b0;
    if (valid_i) begin
      case (op_i)
        OPC_LUI: begin
          dec_s.reg_write = 1'b1; dec_s.imm_src = IMM_U; dec_s.alu_src = 1'b1;
          dec_s.result_src = RES_IMM;
        end
        OPC_AUIPC: begin
          dec_s.reg_write = 1'b1; dec_s.imm_src = IMM_U; dec_s.alu_src = 1'b1;
          dec_s.result_src = RES_PCIMM;
        end
        OPC_JAL: begin
          dec_s.reg_write = 1'b1; dec_s.imm_src = IMM_J; dec_s.result_src = RES_PC4;
          dec_s.jal = 1'b1;
        end
        OPC_JALR: begin
          dec_s.reg_write = 1'b1; dec_s.imm_src = IMM_I; dec_s.alu_src = 1'b1;
          dec_s.result_src = RES_PC4; dec_s.jalr = 1'b1;
        end
        OPC_BRANCH: begin
          dec_s.imm_src = IMM_B; dec_s.alu_ctrl = ALU_SUB; dec_s.branch = 1'b1;
        end
        OPC_LOAD: begin
          dec_s.reg_write = 1'b1; dec_s.imm_src = IMM_I; dec_s.alu_src = 1'b1;
          dec_s.mem_type = funct3_i; dec_s.result_src = RES_MEM;
        end
        OPC_STORE: begin
          dec_s.imm_src = IMM_S; dec_s.alu_src = 1'b1; dec_s.mem_write = 1'b1;
          dec_s.mem_type = funct3_i;
        end
        // funct7[5] only selects arithmetic shift for immediate forms
        OPC_OPIMM, OPC_OPIMM32: begin
          dec_s.reg_write = 1'b1; dec_s.imm_src = IMM_I; dec_s.alu_src = 1'b1;
          dec_s.alu_ctrl = {(funct3_i == 3'b101) ? funct7_i[5] : 1'b0, funct3_i};
          dec_s.alu32 = (op_i == OPC_OPIMM32);
        end
        OPC_OP, OPC_OP32: begin
          if (funct7_i == F7_MULDIV) begin
            if (M_EXT != 0) begin
              dec_s.reg_write = 1'b1; dec_s.alu_ctrl = {1'b0, funct3_i};
              dec_s.alu32 = (op_i == OPC_OP32); dec_s.result_src = RES_MD;
              is_md_s = 1'b1;
            end else begin
              dec_s.illegal = 1'b1;
            end
          end else begin
            dec_s.reg_write = 1'b1; dec_s.alu_ctrl = {funct7_i[5], funct3_i};
            dec_s.alu32 = (op_i == OPC_OP32);
          end
        end
        OPC_SYSTEM: begin
          if (funct3_i == 3'b000) begin
            dec_s.ecall = 1'b1;
          end else begin
            dec_s.illegal = 1'b1;
          end
        end
        default: dec_s.illegal = 1'b1;
      endcase
    end else begin
      dec_s = CTRL_BUBBLE;
    end
  end

  assign hold_s = stall_i | md_stall_r;
  assign load_s = ~flush_i & ~hold_s;
  assign lat_s  = funct3_i[2] ? DIV_LAT_C : MUL_LAT_C;

  // MUL/DIV sequencer next state; DONE accepts a new operation like IDLE
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (flush_i) begin
      state_s = S_IDLE;
      cnt_s   = 8'd0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (load_s && is_md_s) begin
            if (lat_s == 8'd1) begin
              state_s = S_DONE;
              cnt_s   = 8'd0;
            end else begin
              state_s = S_BUSY;
              cnt_s   = lat_s - 8'd1;
            end
          end else begin
            state_s = S_IDLE;
            cnt_s   = 8'd0;
          end
        end
        S_BUSY: begin
          if (cnt_r <= 8'd1) begin
            state_s = S_DONE;
            cnt_s   = 8'd0;
          end else begin
            state_s = S_BUSY;
            cnt_s   = cnt_r - 8'd1;
          end
        end
        default: begin
          state_s = S_IDLE;
          cnt_s   = 8'd0;
        end
      endcase
    end
  end

  // ID/EX register, sequencer state and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_r     <= CTRL_BUBBLE;
      state_r    <= S_IDLE;
      cnt_r      <= 8'd0;
      md_start_r <= 1'b0;
      md_stall_r <= 1'b0;
      md_done_r  <= 1'b0;
    end else begin
      if (flush_i) begin
        ctrl_r <= CTRL_BUBBLE;
      end else if (!hold_s) begin
        ctrl_r <= dec_s;
      end else begin
        ctrl_r <= ctrl_r;
      end
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      md_start_r <= load_s & is_md_s;
      md_stall_r <= (state_s == S_BUSY);
      md_done_r  <= (state_s == S_DONE);
    end
  end

  assign regWrite_e   = ctrl_r.reg_write;
  assign immSrc_e     = ctrl_r.imm_src;
  assign ALUSrc_e     = ctrl_r.alu_src;
  assign ALUControl_e = ctrl_r.alu_ctrl;
  assign ALU32_e      = ctrl_r.alu32;
  assign memWrite_e   = ctrl_r.mem_write;
  assign memType_e    = ctrl_r.mem_type;
  assign resultSrc_e  = ctrl_r.result_src;
  assign branch_e     = ctrl_r.branch;
  assign jal_e        = ctrl_r.jal;
  assign jalr_e       = ctrl_r.jalr;
  assign ecall_e      = ctrl_r.ecall;
  assign illegal_e    = ctrl_r.illegal;
  assign mdStart_e    = md_start_r;
  assign mdStall_o    = md_stall_r;
  assign mdDone_o     = md_done_r;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: decode vector table, hand-written MUL/DIV/stall/flush/reset
// sequences, and a randomized run against a cycle-level reference model.
module tb_decode_ctrl_stage;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 34;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011, OPIMM = 7'b0010011, OPIMM32 = 7'b0011011;
  localparam logic [6:0] OP = 7'b0110011, OP32 = 7'b0111011, SYSTEM = 7'b1110011;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic [3:0] alu_ctrl;
    logic       alu32;
    logic       mem_write;
    logic [2:0] mem_type;
    logic [2:0] result_src;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       ecall;
    logic       illegal;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       valid;
    exp_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic [6:0] op_i, funct7_i;
  logic [2:0] funct3_i;
  logic valid_i, stall_i, flush_i;
  logic regWrite_e, ALUSrc_e, ALU32_e, memWrite_e, branch_e, jal_e, jalr_e, ecall_e, illegal_e;
  logic [2:0] immSrc_e, memType_e, resultSrc_e;
  logic [3:0] ALUControl_e;
  logic mdStart_e, mdStall_o, mdDone_o;
  logic nm_regWrite, nm_ALUSrc, nm_ALU32, nm_memWrite, nm_branch, nm_jal, nm_jalr, nm_ecall;
  logic nm_illegal, nm_mdStart, nm_mdStall, nm_mdDone;
  logic [2:0] nm_immSrc, nm_memType, nm_resultSrc;
  logic [3:0] nm_ALUControl;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  logic [6:0] ops [12] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OPIMM32, OP, OP32, SYSTEM};

  exp_t m_e;
  bit   m_active, m_start;
  int   m_age, m_lat;

  always #5 clk = ~clk;

  decode_ctrl_stage #(.M_EXT(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .op_i(op_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .regWrite_e(regWrite_e), .immSrc_e(immSrc_e), .ALUSrc_e(ALUSrc_e),
    .ALUControl_e(ALUControl_e), .ALU32_e(ALU32_e), .memWrite_e(memWrite_e),
    .memType_e(memType_e), .resultSrc_e(resultSrc_e), .branch_e(branch_e), .jal_e(jal_e),
    .jalr_e(jalr_e), .ecall_e(ecall_e), .illegal_e(illegal_e), .mdStart_e(mdStart_e),
    .mdStall_o(mdStall_o), .mdDone_o(mdDone_o));

  decode_ctrl_stage #(.M_EXT(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_nomext (
    .clk(clk), .reset_n(reset_n), .op_i(op_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .regWrite_e(nm_regWrite), .immSrc_e(nm_immSrc), .ALUSrc_e(nm_ALUSrc),
    .ALUControl_e(nm_ALUControl), .ALU32_e(nm_ALU32), .memWrite_e(nm_memWrite),
    .memType_e(nm_memType), .resultSrc_e(nm_resultSrc), .branch_e(nm_branch), .jal_e(nm_jal),
    .jalr_e(nm_jalr), .ecall_e(nm_ecall), .illegal_e(nm_illegal), .mdStart_e(nm_mdStart),
    .mdStall_o(nm_mdStall), .mdDone_o(nm_mdDone));

  function automatic exp_t mk(input int rw, input int imm, input int as, input int alu,
                              input int a32, input int mw, input int mt, input int rs,
                              input int br, input int jl, input int jr, input int ec,
                              input int il);
    exp_t e;
    e.reg_write = rw[0]; e.imm_src = imm[2:0]; e.alu_src = as[0]; e.alu_ctrl = alu[3:0];
    e.alu32 = a32[0]; e.mem_write = mw[0]; e.mem_type = mt[2:0]; e.result_src = rs[2:0];
    e.branch = br[0]; e.jal = jl[0]; e.jalr = jr[0]; e.ecall = ec[0]; e.illegal = il[0];
    return e;
  endfunction

  function automatic bit ref_is_md(input logic [6:0] op, input logic [6:0] f7, input logic v);
    return v && (op == OP || op == OP32) && f7 == 7'b0000001;
  endfunction

  // Reference decode from the ISA rules: formats I0 S1 B2 U3 J4, results ALU0 MEM1 PC+4 2 IMM3 PC+IMM4 MD5
  function automatic exp_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic v, input bit mext);
    int fn = int'(f3);
    exp_t ill = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    if (!v) return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    case (op)
      LUI:    return mk(1, 3, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
      AUIPC:  return mk(1, 3, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0);
      JAL:    return mk(1, 4, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0);
      JALR:   return mk(1, 0, 1, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0);
      BRANCH: return mk(0, 2, 0, 8, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      LOAD:   return mk(1, 0, 1, 0, 0, 0, fn, 1, 0, 0, 0, 0, 0);
      STORE:  return mk(0, 1, 1, 0, 0, 1, fn, 0, 0, 0, 0, 0, 0);
      OPIMM, OPIMM32:
        return mk(1, 0, 1, (fn == 5 && f7[5]) ? fn + 8 : fn, int'(op == OPIMM32), 0, 0, 0, 0, 0, 0, 0, 0);
      OP, OP32: begin
        if (f7 == 7'b0000001)
          return mext ? mk(1, 0, 0, fn, int'(op == OP32), 0, 0, 5, 0, 0, 0, 0, 0) : ill;
        return mk(1, 0, 0, int'(f7[5]) * 8 + fn, int'(op == OP32), 0, 0, 0, 0, 0, 0, 0, 0);
      end
      SYSTEM: return (fn == 0) ? mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0) : ill;
      default: return ill;
    endcase
  endfunction

  function automatic exp_t act_bundle();
    return {regWrite_e, immSrc_e, ALUSrc_e, ALUControl_e, ALU32_e, memWrite_e, memType_e,
            resultSrc_e, branch_e, jal_e, jalr_e, ecall_e, illegal_e};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic v, input logic st, input logic fl);
    op_i = op; funct3_i = f3; funct7_i = f7; valid_i = v; stall_i = st; flush_i = fl;
  endtask

  task automatic add_vec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic v, input exp_t e);
    vec_t t;
    t.op = op; t.f3 = f3; t.f7 = f7; t.valid = v; t.exp = e;
    vecs.push_back(t);
  endtask

  // Model advances on each edge: an MD op occupies E for its latency, stalling all but the last cycle
  task automatic mdl_step();
    bit md_hold = m_active && (m_age < m_lat);
    if (flush_i) begin
      m_e = '0; m_active = 1'b0; m_start = 1'b0;
    end else if (md_hold) begin
      m_age++; m_start = 1'b0;
    end else if (stall_i) begin
      m_active = 1'b0; m_start = 1'b0;
    end else begin
      m_e = ref_decode(op_i, funct3_i, funct7_i, valid_i, 1'b1);
      m_start = ref_is_md(op_i, funct7_i, valid_i);
      m_active = m_start; m_age = 1;
      m_lat = funct3_i[2] ? DIV_LAT : MUL_LAT;
    end
  endtask

  initial begin
    logic seen;
    logic [6:0] rop, rf7;

    // Reset with a valid OP presented
    reset_n = 1'b0;
    drive(OP, 3'b000, 7'b0000000, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_bundle", 32'(act_bundle()), 32'd0);
    chk("reset_md", 32'({mdStart_e, mdStall_o, mdDone_o}), 32'd0);
    drive(7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= mdStart_e | mdDone_o | mdStall_o; end
    chk("reset_release_md", 32'(seen), 32'd0);

    // Decode table
    add_vec(OP,      3'b000, 7'b0000000, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_vec(OP,      3'b000, 7'b0100000, 1'b1, mk(1, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_vec(OP32,    3'b101, 7'b0100000, 1'b1, mk(1, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add_vec(OPIMM,   3'b000, 7'b0100000, 1'b1, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_vec(OPIMM32, 3'b101, 7'b0100000, 1'b1, mk(1, 0, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add_vec(LOAD,    3'b011, 7'b0000000, 1'b1, mk(1, 0, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0));
    add_vec(STORE,   3'b010, 7'b0000000, 1'b1, mk(0, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0));
    add_vec(BRANCH,  3'b001, 7'b0000000, 1'b1, mk(0, 2, 0, 8, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    add_vec(JAL,     3'b000, 7'b0000000, 1'b1, mk(1, 4, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0));
    add_vec(JALR,    3'b000, 7'b0000000, 1'b1, mk(1, 0, 1, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0));
    add_vec(LUI,     3'b000, 7'b0000000, 1'b1, mk(1, 3, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0));
    add_vec(AUIPC,   3'b000, 7'b0000000, 1'b1, mk(1, 3, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0));
    add_vec(SYSTEM,  3'b000, 7'b0000000, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    add_vec(SYSTEM,  3'b001, 7'b0000000, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add_vec(7'b1111111, 3'b000, 7'b0000000, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add_vec(OP,      3'b000, 7'b0000000, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].valid, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(act_bundle()), 32'(vecs[i].exp));
    end

    // MUL: start+stall, stall, done, then the waiting ADD enters E
    drive(OP, 3'b000, 7'b0000001, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("mul_c1", 32'({mdStart_e, mdStall_o, mdDone_o}), 32'b110);
    chk("mul_result_src", 32'(resultSrc_e), 32'd5);
    drive(OP, 3'b000, 7'b0000000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("mul_c2", 32'({mdStart_e, mdStall_o, mdDone_o}), 32'b010);
    @(negedge clk);
    chk("mul_c3", 32'({mdStart_e, mdStall_o, mdDone_o}), 32'b001);
    chk("mul_held", 32'(resultSrc_e), 32'd5);
    @(negedge clk);
    chk("mul_c4", 32'({mdStart_e, mdStall_o, mdDone_o}), 32'b000);
    chk("add_after_mul", 32'(act_bundle()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));

    // Back-to-back MUL restarts on the cycle after DONE
    drive(OP, 3'b001, 7'b0000001, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("b2b_restart", 32'({mdStart_e, mdStall_o, mdDone_o}), 32'b110);
    drive(7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // DIV aborted by flush during cycle 10
    drive(OP, 3'b100, 7'b0000001, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("div_c1", 32'({mdStart_e, mdStall_o, mdDone_o}), 32'b110);
    drive(OP, 3'b000, 7'b0000000, 1'b1, 1'b0, 1'b0);
    seen = 1'b1;
    repeat (9) begin @(negedge clk); seen &= mdStall_o & ~mdDone_o & ~mdStart_e; end
    chk("div_busy", 32'(seen), 32'd1);
    drive(OP, 3'b000, 7'b0000000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("div_flush_md", 32'({mdStart_e, mdStall_o, mdDone_o}), 32'b000);
    chk("div_flush_bubble", 32'(act_bundle()), 32'd0);
    drive(7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= mdDone_o; end
    chk("div_flush_no_done", 32'(seen), 32'd0);

    // STORE held by stall for two cycles, then flush wins over stall
    drive(STORE, 3'b011, 7'b0000000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("store_load", 32'(act_bundle()), 32'(mk(0, 1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0)));
    drive(OP, 3'b000, 7'b0000000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("store_hold1", 32'(act_bundle()), 32'(mk(0, 1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    chk("store_hold2", 32'(act_bundle()), 32'(mk(0, 1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0)));
    drive(OP, 3'b000, 7'b0000000, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("store_flush", 32'(act_bundle()), 32'd0);

    // Without M extension: unknown opcode and MUL are both illegal
    drive(7'b1111111, 3'b000, 7'b0000000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("nm_bad_op", 32'({nm_illegal, nm_regWrite, nm_memWrite}), 32'b100);
    drive(OP, 3'b000, 7'b0000001, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("nm_mul", 32'({nm_illegal, nm_regWrite, nm_memWrite, nm_mdStart, nm_mdStall}), 32'b10000);
    drive(7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-DIV
    drive(OP, 3'b110, 7'b0000001, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy_md", 32'({mdStart_e, mdStall_o, mdDone_o}), 32'b000);
    chk("rst_busy_bundle", 32'(act_bundle()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= mdDone_o | mdStall_o; end
    chk("rst_busy_no_done", 32'(seen), 32'd0);

    // Randomized run against the reference model
    drive(7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    m_e = '0; m_active = 1'b0; m_start = 1'b0; m_age = 0; m_lat = 1;
    for (int n = 0; n < 800; n++) begin
      rop = ($urandom_range(0, 7) == 0) ? 7'($urandom()) : ops[$urandom_range(0, 11)];
      case ($urandom_range(0, 3))
        0: rf7 = 7'b0000000;
        1: rf7 = 7'b0100000;
        2: rf7 = 7'b0000001;
        default: rf7 = 7'($urandom());
      endcase
      drive(rop, 3'($urandom()), rf7, ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 29) == 0));
      mdl_step();
      @(negedge clk);
      chk($sformatf("rand%0d_bundle", n), 32'(act_bundle()), 32'(m_e));
      chk($sformatf("rand%0d_md", n), 32'({mdStart_e, mdStall_o, mdDone_o}),
          32'({m_start, m_active && (m_age < m_lat), m_active && (m_age == m_lat)}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
